// File: rtl/alu_shift_sequencer.sv
// Issue/capture sequencer around the ALU: runs one or more ALU passes per
// request, feeding ALUOut back into A, then returns result and flags.
module alu_shift_sequencer #(
    parameter int CNT_W           = 5,
    parameter bit WF_ON_LAST_ONLY = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [4:0]       ReqFunSel,
    input  logic [31:0]      ReqA,
    input  logic [31:0]      ReqB,
    input  logic [CNT_W-1:0] ReqCount,
    output logic [31:0]      AluA,
    output logic [31:0]      AluB,
    output logic [4:0]       AluFunSel,
    output logic             AluWF,
    input  logic [31:0]      AluOut,
    input  logic [3:0]       AluFlags,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [31:0]      RspData,
    output logic [3:0]       RspFlags
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SETTLE,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] n_pass;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] req_n;
    logic             shift_class;
    logic             last;

    // Only shift/rotate codes take multiple passes; a zero count still runs once.
    assign shift_class = (ReqFunSel[3:0] >= 4'b1011);
    assign req_n       = (shift_class && (ReqCount != '0)) ? ReqCount : CNT_W'(1);
    assign cnt_next    = cnt + CNT_W'(1);
    assign last        = (cnt_next == n_pass);
    assign ReqReady    = (state == IDLE);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:   if (ReqValid) state_next = EXEC;
            EXEC:   if (last) state_next = SETTLE;
            SETTLE: state_next = RESP;
            RESP:   if (RspReady) state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            AluA      <= '0;
            AluB      <= '0;
            AluFunSel <= '0;
            AluWF     <= 1'b0;
            n_pass    <= '0;
            cnt       <= '0;
            RspValid  <= 1'b0;
            RspData   <= '0;
            RspFlags  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ReqValid) begin
                        AluA      <= ReqA;
                        AluB      <= ReqB;
                        AluFunSel <= ReqFunSel;
                        n_pass    <= req_n;
                        cnt       <= '0;
                        AluWF     <= WF_ON_LAST_ONLY ? (req_n == CNT_W'(1)) : 1'b1;
                    end
                end
                EXEC: begin
                    // AluA doubles as the accumulator across passes.
                    AluA <= AluOut;
                    cnt  <= cnt_next;
                    if (last) begin
                        AluWF <= 1'b0;
                    end else begin
                        AluWF <= WF_ON_LAST_ONLY ?
                                 ((cnt_next + CNT_W'(1)) == n_pass) : 1'b1;
                    end
                end
                SETTLE: begin
                    RspData  <= AluA;
                    RspFlags <= AluFlags;
                    RspValid <= 1'b1;
                end
                RESP: begin
                    if (RspReady) RspValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Scoreboard bench for alu_shift_sequencer with a small behavioural ALU
// (add, LSL32, LSR16, CSL32) and a flag register behind it.
module tb_alu_shift_sequencer;

    logic        Clock;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [4:0]  ReqFunSel;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic [4:0]  ReqCount;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic [4:0]  AluFunSel;
    logic        AluWF;
    logic [31:0] AluOut;
    logic [3:0]  AluFlags;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspData;
    logic [3:0]  RspFlags;

    alu_shift_sequencer #(.CNT_W(5), .WF_ON_LAST_ONLY(1'b0)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqFunSel(ReqFunSel), .ReqA(ReqA), .ReqB(ReqB), .ReqCount(ReqCount),
        .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
        .AluOut(AluOut), .AluFlags(AluFlags),
        .RspValid(RspValid), .RspReady(RspReady),
        .RspData(RspData), .RspFlags(RspFlags)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Behavioural ALU; flags are {Z,C,N,O}
    logic        alu_rst;
    logic [3:0]  alu_flags;
    logic [3:0]  flag_in;
    logic [32:0] sum;
    assign AluFlags = alu_flags;

    always_comb begin
        sum     = '0;
        AluOut  = AluA;
        flag_in = alu_flags;
        case (AluFunSel)
            5'b10100: begin
                sum        = {1'b0, AluA} + {1'b0, AluB};
                AluOut     = sum[31:0];
                flag_in[2] = sum[32];
                flag_in[0] = (AluA[31] == AluB[31]) && (sum[31] != AluA[31]);
            end
            5'b11011: begin
                AluOut     = {AluA[30:0], 1'b0};
                flag_in[2] = AluA[31];
            end
            5'b01100: begin
                AluOut     = {17'h0, AluA[15:1]};
                flag_in[2] = AluA[0];
            end
            5'b11110: begin
                AluOut     = {AluA[30:0], alu_flags[2]};
                flag_in[2] = AluA[31];
            end
            default: AluOut = AluA;
        endcase
        if (AluFunSel[4]) begin
            flag_in[3] = (AluOut == 32'h0);
            flag_in[1] = AluOut[31];
        end else begin
            flag_in[3] = (AluOut[15:0] == 16'h0);
            flag_in[1] = AluOut[15];
        end
    end

    always @(posedge Clock) begin
        if (alu_rst) alu_flags <= 4'h0;
        else if (AluWF) alu_flags <= flag_in;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
        int          cyc;
        int          wf;
    } exp_t;

    exp_t sb[$];

    // Monitor: pops one expectation per response, then watches stability.
    int          wf_cnt = 0;
    bit          in_rsp = 0;
    logic [31:0] held_data;
    logic [3:0]  held_flags;

    always @(negedge Clock) begin
        exp_t cur;
        if (Reset) begin
            wf_cnt = 0;
            in_rsp = 0;
        end else begin
            if (AluWF) wf_cnt++;
            if (!RspValid) begin
                in_rsp = 0;
            end else if (!in_rsp) begin
                in_rsp     = 1;
                held_data  = RspData;
                held_flags = RspFlags;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(RspValid), 32'h0);
                end else begin
                    cur = sb.pop_front();
                    chk("rsp_data", RspData, cur.data);
                    chk("rsp_flags", 32'(RspFlags), 32'(cur.flags));
                    chk("rsp_latency", 32'(cyc), 32'(cur.cyc));
                    chk("wf_pulses", 32'(wf_cnt), 32'(cur.wf));
                end
                wf_cnt = 0;
            end else begin
                chk("rsp_data_stable", RspData, held_data);
                chk("rsp_flags_stable", 32'(RspFlags), 32'(held_flags));
            end
        end
    end

    task automatic issue(input logic [4:0] fs, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] cnt,
                         input logic [31:0] data, input logic [3:0] flags,
                         input int n, input bit push);
        int t = 0;
        @(negedge Clock);
        while (!ReqReady && t < 100) begin
            @(negedge Clock);
            t++;
        end
        if (!ReqReady) chk("req_ready_timeout", 32'(ReqReady), 32'h1);
        ReqValid  = 1'b1;
        ReqFunSel = fs;
        ReqA      = a;
        ReqB      = b;
        ReqCount  = cnt;
        if (push) sb.push_back('{data, flags, cyc + 1 + n + 1, n});
        @(negedge Clock);
        ReqValid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || RspValid) && t < 200) begin
            @(negedge Clock);
            t++;
        end
        if (t >= 200) chk("drain_timeout", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        int t;
        Reset     = 1'b1;
        alu_rst   = 1'b1;
        ReqValid  = 1'b0;
        ReqFunSel = '0;
        ReqA      = '0;
        ReqB      = '0;
        ReqCount  = '0;
        RspReady  = 1'b1;
        repeat (3) @(negedge Clock);
        Reset   = 1'b0;
        alu_rst = 1'b0;
        @(negedge Clock);
        chk("rst_req_ready", 32'(ReqReady), 32'h1);
        chk("rst_rsp_valid", 32'(RspValid), 32'h0);
        chk("rst_alu_wf", 32'(AluWF), 32'h0);
        chk("rst_alu_a", AluA, 32'h0);
        chk("rst_alu_b", AluB, 32'h0);
        chk("rst_alu_funsel", 32'(AluFunSel), 32'h0);
        chk("rst_rsp_data", RspData, 32'h0);
        chk("rst_rsp_flags", 32'(RspFlags), 32'h0);

        // T1: add ignores count
        issue(5'b10100, 32'd5, 32'd7, 5'd9, 32'd12, 4'b0000, 1, 1);
        // T2: LSL32 by 4
        issue(5'b11011, 32'h1, 32'h0, 5'd4, 32'h10, 4'b0000, 4, 1);
        // T3: CSL32 twice, carry chained through the flag register
        issue(5'b11110, 32'h8000_0000, 32'h0, 5'd2, 32'h1, 4'b0000, 2, 1);
        // T4: LSR16, count 0 means one pass
        issue(5'b01100, 32'h0000_8000, 32'h0, 5'd0, 32'h4000, 4'b0000, 1, 1);
        // wrap to zero: Z and C set
        issue(5'b10100, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 4'b1100, 1, 1);
        drain();

        // T5: back-pressure with a competing request
        RspReady = 1'b0;
        issue(5'b10100, 32'd3, 32'd4, 5'd0, 32'd7, 4'b0000, 1, 1);
        t = 0;
        while (!RspValid && t < 20) begin
            @(negedge Clock);
            t++;
        end
        chk("t5_rsp_valid", 32'(RspValid), 32'h1);
        ReqValid  = 1'b1;
        ReqFunSel = 5'b10100;
        ReqA      = 32'd100;
        ReqB      = 32'd1;
        repeat (3) begin
            @(negedge Clock);
            chk("t5_req_ready_low", 32'(ReqReady), 32'h0);
            chk("t5_rsp_held", 32'(RspValid), 32'h1);
        end
        ReqValid = 1'b0;
        RspReady = 1'b1;
        @(negedge Clock);
        chk("t5_req_ready_after", 32'(ReqReady), 32'h1);
        chk("t5_rsp_valid_after", 32'(RspValid), 32'h0);

        // T6: reset in the middle of a 10-pass shift
        issue(5'b11011, 32'h1, 32'h0, 5'd10, 32'h0, 4'h0, 10, 0);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        #1;
        chk("t6_req_ready", 32'(ReqReady), 32'h1);
        chk("t6_rsp_valid", 32'(RspValid), 32'h0);
        chk("t6_alu_wf", 32'(AluWF), 32'h0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (15) @(negedge Clock);
        chk("t6_no_rsp", 32'(RspValid), 32'h0);
        issue(5'b10100, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 4'b0011, 1, 1);
        drain();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
